// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the instruction-fetch sequencer.
package fetch_pkg;

   localparam int unsigned PW_DEF     = 16;
   localparam int unsigned SDEPTH_DEF = 4;

   // Stack-pointer width for the default stack depth (counts 0..SDEPTH).
   localparam int unsigned SPW = $clog2(SDEPTH_DEF + 1);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone,
      StFault
   } fetch_state_t;

   // Stack-pointer width for an arbitrary depth (counts 0..sdepth).
   function automatic int unsigned spw_of(input int unsigned sdepth);
      return $clog2(sdepth + 1);
   endfunction

   // Program-select width, never narrower than one bit.
   function automatic int unsigned sel_w(input int unsigned nprog);
      return (nprog > 1) ? $clog2(nprog) : 1;
   endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO for call/return control flow.
module ret_stack
   import fetch_pkg::*;
#(
   parameter int unsigned PW     = PW_DEF,
   parameter int unsigned SDEPTH = SDEPTH_DEF
) (
   input  logic          CLK,
   input  logic          Init,
   input  logic          push,
   input  logic          pop,
   input  logic          clear,
   input  logic [PW-1:0] din,
   output logic          full,
   output logic          empty,
   output logic [PW-1:0] top
);

   localparam int unsigned SW = spw_of(SDEPTH);

   logic [PW-1:0] r_mem [SDEPTH];
   logic [SW-1:0] r_sp;
   logic [PW-1:0] w_top;

   // Stack pointer: number of valid entries; clear and reset both empty the stack.
   always_ff @(posedge CLK) begin
      if (Init || clear) begin
         r_sp <= '0;
      end else if (push) begin
         r_sp <= r_sp + 1'b1;
      end else if (pop) begin
         r_sp <= r_sp - 1'b1;
      end
   end

   // Entry storage: a push writes the slot just above the current top.
   always_ff @(posedge CLK) begin
      for (int i = 0; i < int'(SDEPTH); i++) begin
         if (push && !clear && !Init && (r_sp == SW'(i))) begin
            r_mem[i] <= din;
         end
      end
   end

   // Top-of-stack read; reads zero when empty.
   always_comb begin
      w_top = '0;
      for (int i = 0; i < int'(SDEPTH); i++) begin
         if (r_sp == SW'(i + 1)) begin
            w_top = r_mem[i];
         end
      end
   end

   assign top   = w_top;
   assign full  = (r_sp == SW'(SDEPTH));
   assign empty = (r_sp == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: runs one bounded program with branch/call/return flow.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int unsigned                  PW         = PW_DEF,
   parameter int unsigned                  NPROG      = 3,
   parameter logic [NPROG-1:0][PW-1:0]     PROG_START = '0,
   parameter logic [NPROG-1:0][PW-1:0]     PROG_END   = '0,
   parameter int unsigned                  SDEPTH     = SDEPTH_DEF,
   localparam int unsigned                 SELW       = sel_w(NPROG)
) (
   input  logic            CLK,
   input  logic            Init,
   input  logic            Start,
   input  logic [SELW-1:0] ProgSel,
   input  logic            Stall,
   input  logic            Branch_abs,
   input  logic            Branch_rel_z,
   input  logic            Branch_rel_nz,
   input  logic            Call,
   input  logic            Ret,
   input  logic            ALU_zero,
   input  logic [PW-1:0]   Target,
   output logic [PW-1:0]   PC,
   output logic [SELW-1:0] ProgIdx,
   output logic            Running,
   output logic            DONE,
   output logic            Fault
);

   fetch_state_t    r_state;
   logic [PW-1:0]   r_pc;
   logic [SELW-1:0] r_prog_idx;
   logic            r_running;
   logic            r_done;
   logic            r_fault;

   logic [PW-1:0]   w_pc_inc;
   logic [PW-1:0]   w_pc_rel;
   logic [PW-1:0]   w_pc_next;
   logic [PW-1:0]   w_top;
   logic            w_full;
   logic            w_empty;
   logic            w_at_end;
   logic            w_start_ok;
   logic            w_launch;
   logic            w_step;
   logic            w_fault_req;
   logic            w_push;
   logic            w_pop;

   assign w_pc_inc   = r_pc + 1'b1;
   assign w_pc_rel   = r_pc + Target;
   assign w_at_end   = (r_pc == PROG_END[r_prog_idx]);
   assign w_start_ok = Start && (32'(ProgSel) < NPROG);
   assign w_launch   = ((r_state == StIdle) || (r_state == StDone)) && w_start_ok;

   // An active RUN cycle that is neither stalled nor the final fetch.
   assign w_step      = (r_state == StRun) && !Stall && !w_at_end;
   assign w_fault_req = (Ret && w_empty) || (!Ret && Call && w_full);
   assign w_pop       = w_step && Ret && !w_empty;
   assign w_push      = w_step && !Ret && Call && !w_full;

   // Next PC for a RUN step, in control-flow priority order.
   always_comb begin
      w_pc_next = w_pc_inc;
      if (Ret) begin
         w_pc_next = w_top;
      end else if (Call) begin
         w_pc_next = Target;
      end else if (Branch_abs) begin
         w_pc_next = Target;
      end else if (Branch_rel_z && ALU_zero) begin
         w_pc_next = w_pc_rel;
      end else if (Branch_rel_nz && !ALU_zero) begin
         w_pc_next = w_pc_rel;
      end
   end

   ret_stack #(
      .PW     (PW),
      .SDEPTH (SDEPTH)
   ) u_ret_stack (
      .CLK   (CLK),
      .Init  (Init),
      .push  (w_push),
      .pop   (w_pop),
      .clear (w_launch),
      .din   (w_pc_inc),
      .full  (w_full),
      .empty (w_empty),
      .top   (w_top)
   );

   // Sequencer FSM with registered PC, program index and status flags.
   always_ff @(posedge CLK) begin
      if (Init) begin
         r_state    <= StIdle;
         r_pc       <= '0;
         r_prog_idx <= '0;
         r_running  <= 1'b0;
         r_done     <= 1'b0;
         r_fault    <= 1'b0;
      end else begin
         case (r_state)
            StIdle, StDone: begin
               if (w_launch) begin
                  r_state    <= StRun;
                  r_pc       <= PROG_START[ProgSel];
                  r_prog_idx <= ProgSel;
                  r_running  <= 1'b1;
                  r_done     <= 1'b0;
               end
            end
            StRun: begin
               if (Stall) begin
                  r_state <= StRun;
               end else if (w_at_end) begin
                  r_state   <= StDone;
                  r_running <= 1'b0;
                  r_done    <= 1'b1;
               end else if (w_fault_req) begin
                  r_state   <= StFault;
                  r_running <= 1'b0;
                  r_fault   <= 1'b1;
               end else begin
                  r_pc <= w_pc_next;
               end
            end
            StFault: begin
               r_state <= StFault;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign PC      = r_pc;
   assign ProgIdx = r_prog_idx;
   assign Running = r_running;
   assign DONE    = r_done;
   assign Fault   = r_fault;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        init, start, prog_sel;
   logic        stall, b_abs, b_z, b_nz, call, ret, alu_zero;
   logic [15:0] target;
   logic [15:0] pc;
   logic        prog_idx, running, done, fault;

   // Second instance: three programs, all bounds zero.
   logic        init2, start2;
   logic [1:0]  sel2;
   logic [15:0] pc2;
   logic [1:0]  idx2;
   logic        running2, done2, fault2;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fetch_sequencer #(
      .PW         (16),
      .NPROG      (2),
      .PROG_START ({16'd124, 16'd0}),
      .PROG_END   ({16'd300, 16'd123}),
      .SDEPTH     (2)
   ) dut (
      .CLK           (clk),
      .Init          (init),
      .Start         (start),
      .ProgSel       (prog_sel),
      .Stall         (stall),
      .Branch_abs    (b_abs),
      .Branch_rel_z  (b_z),
      .Branch_rel_nz (b_nz),
      .Call          (call),
      .Ret           (ret),
      .ALU_zero      (alu_zero),
      .Target        (target),
      .PC            (pc),
      .ProgIdx       (prog_idx),
      .Running       (running),
      .DONE          (done),
      .Fault         (fault)
   );

   fetch_sequencer #(
      .PW     (16),
      .NPROG  (3),
      .SDEPTH (1)
   ) dut2 (
      .CLK           (clk),
      .Init          (init2),
      .Start         (start2),
      .ProgSel       (sel2),
      .Stall         (stall),
      .Branch_abs    (b_abs),
      .Branch_rel_z  (b_z),
      .Branch_rel_nz (b_nz),
      .Call          (call),
      .Ret           (ret),
      .ALU_zero      (alu_zero),
      .Target        (target),
      .PC            (pc2),
      .ProgIdx       (idx2),
      .Running       (running2),
      .DONE          (done2),
      .Fault         (fault2)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_ctl();
      init = 0; start = 0; prog_sel = 0; stall = 0; b_abs = 0; b_z = 0; b_nz = 0;
      call = 0; ret = 0; alu_zero = 0; target = '0;
   endtask

   task automatic launch(input logic sel);
      start = 1; prog_sel = sel;
      tick();
      start = 0;
   endtask

   task automatic jump(input logic [15:0] t);
      b_abs = 1; target = t;
      tick();
      b_abs = 0;
   endtask

   initial begin
      clr_ctl();
      init2 = 1; start2 = 0; sel2 = 0;
      init = 1;
      tick(); tick();
      check_eq("rst_pc", pc, 0);
      check_eq("rst_idx", prog_idx, 0);
      check_eq("rst_running", running, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_fault", fault, 0);
      init = 0; init2 = 0;

      // Branches ignored while idle.
      stall = 1; b_abs = 1; target = 16'd99;
      tick();
      check_eq("idle_hold_pc", pc, 0);
      clr_ctl();

      // Program 1 runs 124..300 then DONE.
      launch(1'b1);
      check_eq("p1_start_pc", pc, 124);
      check_eq("p1_running", running, 1);
      check_eq("p1_idx", prog_idx, 1);
      repeat (176) tick();
      check_eq("p1_end_pc", pc, 300);
      check_eq("p1_end_notdone", done, 0);
      tick();
      check_eq("p1_done", done, 1);
      check_eq("p1_done_pc", pc, 300);
      check_eq("p1_done_run", running, 0);
      jump(16'd5);
      check_eq("done_hold_pc", pc, 300);
      check_eq("done_level", done, 1);

      // Restart from DONE with program 0.
      launch(1'b0);
      check_eq("p0_pc", pc, 0);
      check_eq("p0_done_clr", done, 0);
      check_eq("p0_running", running, 1);
      check_eq("p0_idx", prog_idx, 0);

      // Relative branches.
      jump(16'd10);
      check_eq("abs_10", pc, 10);
      b_nz = 1; alu_zero = 0; target = 16'hFFFD;
      tick();
      check_eq("rel_nz_taken", pc, 7);
      b_nz = 0;
      jump(16'd10);
      b_nz = 1; alu_zero = 1; target = 16'hFFFD;
      tick();
      check_eq("rel_nz_not_taken", pc, 11);
      b_nz = 0; b_z = 1; alu_zero = 1; target = 16'd2;
      tick();
      check_eq("rel_z_taken", pc, 13);
      clr_ctl();

      // Start during RUN is ignored.
      launch(1'b1);
      check_eq("run_start_pc", pc, 14);
      check_eq("run_start_idx", prog_idx, 0);

      // PC wraps modulo 2^16.
      jump(16'hFFFF);
      check_eq("wrap_pre", pc, 16'hFFFF);
      tick();
      check_eq("wrap_post", pc, 0);

      // Stack overflow faults.
      jump(16'd5);
      call = 1; target = 16'd40;
      tick();
      check_eq("call1_pc", pc, 40);
      target = 16'd60;
      tick();
      check_eq("call2_pc", pc, 60);
      target = 16'd70;
      tick();
      check_eq("call3_fault", fault, 1);
      check_eq("call3_pc", pc, 60);
      check_eq("call3_running", running, 0);
      call = 0; start = 1; prog_sel = 0;
      tick();
      check_eq("fault_hold_pc", pc, 60);
      check_eq("fault_sticky", fault, 1);
      start = 0; init = 1;
      tick();
      init = 0;
      check_eq("fault_init_pc", pc, 0);
      check_eq("fault_init_flag", fault, 0);

      // Call/return and pop priority.
      launch(1'b0);
      jump(16'd5);
      call = 1; target = 16'd40;
      tick();
      call = 0; ret = 1;
      tick();
      check_eq("ret_pc", pc, 6);
      ret = 0; call = 1; target = 16'd20;
      tick();
      check_eq("call_20", pc, 20);
      call = 0; ret = 1; b_abs = 1; target = 16'd77;
      tick();
      check_eq("ret_over_abs", pc, 7);
      b_abs = 0;
      tick();
      check_eq("ret_empty_fault", fault, 1);
      check_eq("ret_empty_pc", pc, 7);
      clr_ctl(); init = 1;
      tick();
      init = 0;

      // Stall holds over a pending branch.
      launch(1'b0);
      stall = 1; b_abs = 1; target = 16'd99;
      tick(); tick(); tick();
      check_eq("stall_hold", pc, 0);
      stall = 0;
      tick();
      check_eq("stall_release", pc, 99);
      clr_ctl();

      // Init mid-run.
      jump(16'd50);
      check_eq("mid_pc", pc, 50);
      init = 1;
      tick();
      init = 0;
      check_eq("mid_init_pc", pc, 0);
      check_eq("mid_init_run", running, 0);

      // Out-of-range select, then single-fetch program.
      start2 = 1; sel2 = 2'd3;
      tick();
      check_eq("badsel_running", running2, 0);
      check_eq("badsel_pc", pc2, 0);
      sel2 = 2'd0;
      tick();
      start2 = 0;
      check_eq("one_running", running2, 1);
      check_eq("one_pc", pc2, 0);
      tick();
      check_eq("one_done", done2, 1);
      check_eq("one_done_run", running2, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
